// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore control FSM for the multi-cycle RV32I core. Sequences fetch, decode,
// execute, memory and writeback over several cycles on a shared-memory
// datapath, stalls memory accesses on mem_ready with a timeout trap, and
// counts retired instructions.
//
// Optional feature macro: MC_JAL_EN (when defined, jal is executed through a
// dedicated JAL state; when undefined, jal is an illegal opcode).
//
// Parameters:
//   WAIT_W    width of the memory wait counter
//   WAIT_MAX  stall cycles per memory access before trapping (0 = no timeout)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   op         opcode from the instruction register
//   zero       ALU zero flag
//   mem_ready  memory access completes this cycle
//   PCWrite    PC load enable (PCUpdate | Branch & zero)
//   AdrSrc     memory address select (0 PC, 1 ALUOut)
//   MemWrite   memory write strobe
//   IRWrite    instruction register / OldPC load enable
//   RegWrite   register file write enable
//   ResultSrc  result mux select (00 ALUOut, 01 read data, 10 ALUResult)
//   ALUSrcA    ALU operand A select (00 PC, 01 OldPC, 10 rs1)
//   ALUSrcB    ALU operand B select (00 rs2, 01 imm, 10 constant 4)
//   ALUop      ALU op class (00 add, 01 sub, 10 funct decode)
//   ImmSrc     immediate format (00 I, 01 S, 10 B, 11 J)
//   illegal    sticky trap flag
//   instret    retired-instruction count
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic [1:0]       ImmSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Last counter value before a still-stalled access traps.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
`ifdef MC_JAL_EN
        S_JAL,
`endif
        S_TRAP
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    logic pc_update;
    logic branch;
    logic retire;
    logic timeout;
    logic in_wait;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        retire    = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUop     = 2'b00;
        ImmSrc    = 2'b00;
        illegal   = 1'b0;
        in_wait   = 1'b0;
        // mem_ready in the same cycle takes priority over the timeout.
        timeout   = (WAIT_MAX != 0) && !mem_ready && (wait_q == WAIT_LAST);

        case (state_q)
            S_FETCH: begin
                in_wait   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                if (mem_ready)    state_d = S_DECODE;
                else if (timeout) state_d = S_TRAP;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MC_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                in_wait = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready)    state_d = S_MEMWB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                in_wait  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUop   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`endif
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase

        // Immediate format follows the opcode everywhere except in the trap.
        if (state_q != S_TRAP) begin
            case (op)
                OP_SW:   ImmSrc = 2'b01;
                OP_BEQ:  ImmSrc = 2'b10;
`ifdef MC_JAL_EN
                OP_JAL:  ImmSrc = 2'b11;
`endif
                default: ImmSrc = 2'b00;
            endcase
        end

        PCWrite = pc_update | (branch & zero);

        // Counter restarts on every state change; only wait states count up.
        wait_d = wait_q;
        if (state_d != state_q)      wait_d = '0;
        else if (in_wait && !mem_ready) wait_d = wait_q + 1'b1;

        instret_d = retire ? instret_q + 1'b1 : instret_q;

        // Reset holds the state at FETCH, whose outputs would otherwise
        // follow mem_ready; force every control low while reset is asserted.
        if (!rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 2'b00;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ALUop     = 2'b00;
            ImmSrc    = 2'b00;
            illegal   = 1'b0;
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc;
    logic [31:0] instret;

    multicycle_controller #(.WAIT_W(8), .WAIT_MAX(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUop(ALUop),
        .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    // Phases of instruction execution as listed in the control table.
    typedef enum int {
        P_FETCH, P_DEC, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
        P_EXR, P_EXI, P_ALUWB, P_BEQ, P_JAL, P_TRAP
    } phase_t;

    typedef struct packed {
        logic [14:0] ctrl;
        logic        ill;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    bit   mon_en = 1'b1;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == OP_SW)  return 2'b01;
        if (o == OP_BEQ) return 2'b10;
`ifdef MC_JAL_EN
        if (o == OP_JAL) return 2'b11;
`endif
        return 2'b00;
    endfunction

    // Control word expected for one cycle of a given phase.
    function automatic logic [14:0] word(input phase_t p, input logic mr,
                                         input logic z, input logic [6:0] o);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, a, b, aop, imm;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; a = 0; b = 0; aop = 0; imm = imm_of(o);
        case (p)
            P_FETCH:  begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
            P_DEC:    begin a = 2'b01; b = 2'b01; end
            P_MEMADR: begin a = 2'b10; b = 2'b01; end
            P_MEMRD:  begin adr = 1; end
            P_MEMWB:  begin rs = 2'b01; rw = 1; end
            P_MEMWR:  begin adr = 1; mw = 1; end
            P_EXR:    begin a = 2'b10; aop = 2'b10; end
            P_EXI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            P_ALUWB:  begin rw = 1; end
            P_BEQ:    begin a = 2'b10; aop = 2'b01; pcw = z; end
            P_JAL:    begin a = 2'b01; b = 2'b10; pcw = 1; end
            default:  begin imm = 2'b00; end
        endcase
        return {pcw, adr, mw, irw, rw, rs, a, b, aop, imm};
    endfunction

    // Push the expectation for one cycle, then drive that cycle.
    task automatic step(input phase_t p, input logic mr);
        exp_t e;
        e.ctrl = word(p, mr, zero, op);
        e.ill  = (p == P_TRAP);
        e.cnt  = model_cnt;
        sb.push_back(e);
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: k1 stall cycles in fetch, k2 in the memory access.
    task automatic run_instr(input logic [6:0] o, input logic z,
                             input int k1, input int k2);
        op   = o;
        zero = z;
        for (int c = 0; c < k1; c++) step(P_FETCH, 1'b0);
        step(P_FETCH, 1'b1);
        step(P_DEC, rnd_bit());
        if (o == OP_LW) begin
            step(P_MEMADR, rnd_bit());
            for (int c = 0; c < k2; c++) step(P_MEMRD, 1'b0);
            step(P_MEMRD, 1'b1);
            step(P_MEMWB, rnd_bit());
            model_cnt++;
        end else if (o == OP_SW) begin
            step(P_MEMADR, rnd_bit());
            for (int c = 0; c < k2; c++) step(P_MEMWR, 1'b0);
            step(P_MEMWR, 1'b1);
            model_cnt++;
        end else if (o == OP_R || o == OP_I) begin
            step((o == OP_R) ? P_EXR : P_EXI, rnd_bit());
            step(P_ALUWB, rnd_bit());
            model_cnt++;
        end else if (o == OP_BEQ) begin
            step(P_BEQ, rnd_bit());
            model_cnt++;
`ifdef MC_JAL_EN
        end else if (o == OP_JAL) begin
            step(P_JAL, rnd_bit());
            step(P_ALUWB, rnd_bit());
            model_cnt++;
`endif
        end else begin
            // Unsupported opcode: trap holds until reset.
            for (int c = 0; c < 20; c++) step(P_TRAP, rnd_bit());
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        mem_ready = 1'b1;
        model_cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
    endtask

    // Monitor: one comparison per cycle against the scoreboard.
    always @(negedge clk) begin
        logic [14:0] c;
        exp_t e;
        c = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc};
        if (mon_en) begin
            if (!rst) begin
                checks++;
                if (c !== 15'd0 || illegal !== 1'b0 || instret !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_state: got ctrl=%h illegal=%b instret=%0d, want ctrl=0 illegal=0 instret=0",
                             c, illegal, instret);
                end
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL no_expectation: DUT cycle at %0t with empty scoreboard", $time);
            end else begin
                e = sb.pop_front();
                checks++;
                if (c !== e.ctrl || illegal !== e.ill || instret !== e.cnt) begin
                    errors++;
                    $display("FAIL cycle_%0t: got ctrl=%b illegal=%b instret=%0d, want ctrl=%b illegal=%b instret=%0d (op=%b zero=%b mem_ready=%b)",
                             $time, c, illegal, instret, e.ctrl, e.ill, e.cnt, op, zero, mem_ready);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] ops [6];
        int n_ops;
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
        ops[3] = OP_I;  ops[4] = OP_BEQ; ops[5] = OP_JAL;
`ifdef MC_JAL_EN
        n_ops = 6;
`else
        n_ops = 5;
`endif
        #1;
        do_reset();

        // Directed cases, including stall boundaries at WAIT_MAX-1 lows.
        run_instr(OP_LW,  1'b0, 0, 0);
        run_instr(OP_SW,  1'b0, 0, 3);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_R,   1'b1, 15, 0);
        run_instr(OP_LW,  1'b0, 1, 15);
        run_instr(OP_SW,  1'b1, 2, 15);
        run_instr(OP_I,   1'b0, 0, 0);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            run_instr(ops[$urandom_range(0, n_ops - 1)], rnd_bit(),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end

        // Illegal opcode traps after decode and holds.
        run_instr(OP_BAD, 1'b0, 1, 0);
        do_reset();

        // Fetch timeout: 16 stalled cycles, then trap.
        op = OP_R;
        for (int c = 0; c < 16; c++) step(P_FETCH, 1'b0);
        for (int c = 0; c < 5; c++) step(P_TRAP, rnd_bit());
        do_reset();

        // jal: executes when enabled, traps otherwise.
        run_instr(OP_JAL, 1'b1, 1, 0);
`ifndef MC_JAL_EN
        do_reset();
`endif
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b1, 0, 0);

        mon_en = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
